// File: rtl/rc_fork_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc_fork_pipe_pkg
// Description : Shared routing definitions: port indices and XY unicast route.
// Revision    : 1.0 - initial release
// ============================================================================
package rc_fork_pipe_pkg;

    localparam int PORT_N      = 0;
    localparam int PORT_E      = 1;
    localparam int PORT_S      = 2;
    localparam int PORT_W      = 3;
    localparam int PORT_L      = 4;
    localparam int NUM_UC_PORT = 5;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic logic [NUM_UC_PORT-1:0] xy_route(
        input int dst,
        input int mesh_x,
        input int cur_x,
        input int cur_y
    );
        logic [NUM_UC_PORT-1:0] r;
        int dx;
        int dy;
        r  = '0;
        dx = dst % mesh_x;
        dy = dst / mesh_x;
        if (dx > cur_x)
            r[PORT_E] = 1'b1;
        else if (dx < cur_x)
            r[PORT_W] = 1'b1;
        else if (dy < cur_y)
            r[PORT_N] = 1'b1;
        else if (dy > cur_y)
            r[PORT_S] = 1'b1;
        else
            r[PORT_L] = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc_route_calc.sv
`default_nettype none
// ============================================================================
// Module      : rc_route_calc
// Description : Combinational route computation (XY unicast / mask multicast).
// Revision    : 1.0 - initial release
// ============================================================================
module rc_route_calc
    import rc_fork_pipe_pkg::*;
#(
    parameter int NETWORK_SIZE = 16,
    parameter int MESH_X       = 4,
    parameter int CUR_X        = 1,
    parameter int CUR_Y        = 1,
    parameter int NUM_PORT     = 5,
    parameter int DST_W        = (NETWORK_SIZE > 1) ? $clog2(NETWORK_SIZE) : 1
) (
    input  logic                             mc,
    input  logic [DST_W-1:0]                 dst,
    input  logic [NETWORK_SIZE-1:0]          dst_list,
    input  logic [NUM_PORT*NETWORK_SIZE-1:0] port_mask,
    output logic [NUM_PORT-1:0]              route
);

    logic [NUM_UC_PORT-1:0] w_uc;
    logic [NUM_PORT-1:0]    w_uc_ext;
    logic [NUM_PORT-1:0]    w_mc;

    assign w_uc = xy_route(int'(dst), MESH_X, CUR_X, CUR_Y);

    // Ports beyond the mesh directions are reachable only by multicast.
    for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
        if (p < NUM_UC_PORT) begin : g_xy
            assign w_uc_ext[p] = w_uc[p];
        end else begin : g_mc_only
            assign w_uc_ext[p] = 1'b0;
        end
        assign w_mc[p] = |(dst_list & port_mask[p*NETWORK_SIZE +: NETWORK_SIZE]);
    end

    assign route = mc ? w_mc : w_uc_ext;

endmodule
`default_nettype wire

// File: rtl/rc_fork_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rc_fork_pipe
// Description : Route-compute stage with a one-deep fork register that emits
//               unicast flits whole and splits multicast into per-port beats.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_fork_pipe
    import rc_fork_pipe_pkg::*;
#(
    parameter int NETWORK_SIZE = 16,
    parameter int MESH_X       = 4,
    parameter int CUR_X        = 1,
    parameter int CUR_Y        = 1,
    parameter int NUM_PORT     = 5,
    parameter int SPLIT_MC     = 1,
    parameter int DST_W        = (NETWORK_SIZE > 1) ? $clog2(NETWORK_SIZE) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_mc,
    input  logic [DST_W-1:0]                 in_dst,
    input  logic [NETWORK_SIZE-1:0]          in_dstList,
    input  logic [NUM_PORT*NETWORK_SIZE-1:0] portMask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_PORT-1:0]              out_ppv,
    output logic [NETWORK_SIZE-1:0]          out_dstList,
    output logic                             out_last,
    output logic                             drop_pulse
);

    logic [NUM_PORT-1:0]     r_rem;
    logic                    r_mc;
    logic [NETWORK_SIZE-1:0] r_dst_list;
    logic                    r_drop;

    logic [NUM_PORT-1:0]     w_route;
    logic [NUM_PORT-1:0]     w_low;
    logic [NUM_PORT-1:0]     w_rem_next;
    logic [NETWORK_SIZE-1:0] w_sel_mask;
    logic                    w_split;
    logic                    w_valid;
    logic                    w_beat_done;
    logic                    w_accept;

    rc_route_calc #(
        .NETWORK_SIZE (NETWORK_SIZE),
        .MESH_X       (MESH_X),
        .CUR_X        (CUR_X),
        .CUR_Y        (CUR_Y),
        .NUM_PORT     (NUM_PORT),
        .DST_W        (DST_W)
    ) u_route_calc (
        .mc        (in_mc),
        .dst       (in_dst),
        .dst_list  (in_dstList),
        .port_mask (portMask),
        .route     (w_route)
    );

    assign w_split = (SPLIT_MC != 0) && r_mc;
    assign w_low   = r_rem & (~r_rem + NUM_PORT'(1));

    // Mask is looked up live so that a mask update applies from the next beat.
    always_comb begin
        w_sel_mask = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (w_low[p])
                w_sel_mask = w_sel_mask | portMask[p*NETWORK_SIZE +: NETWORK_SIZE];
        end
    end

    assign w_rem_next  = w_split ? (r_rem & ~w_low) : '0;
    assign w_valid     = !reset && (r_rem != '0);
    assign w_beat_done = w_valid && out_ready;
    assign w_accept    = in_valid && in_ready;

    assign out_valid   = w_valid;
    assign out_last    = w_valid && (w_rem_next == '0);
    assign out_ppv     = !w_valid ? '0 : (w_split ? w_low : r_rem);
    assign out_dstList = !w_valid ? '0 : (w_split ? (r_dst_list & w_sel_mask) : r_dst_list);
    assign in_ready    = !reset && ((r_rem == '0) || (w_beat_done && out_last));
    assign drop_pulse  = !reset && r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem      <= '0;
            r_mc       <= 1'b0;
            r_dst_list <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_accept) begin
                r_rem      <= w_route;
                r_mc       <= in_mc;
                r_dst_list <= in_dstList;
                r_drop     <= in_mc && (w_route == '0);
            end else if (w_beat_done) begin
                r_rem <= w_rem_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc_fork_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_fork_pipe
// Description : Directed self-checking bench for rc_fork_pipe (split and whole).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_fork_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_mc;
    logic [3:0]  in_dst;
    logic [15:0] in_dstList;
    logic [79:0] portMask;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_last, a_drop;
    logic [4:0]  a_ppv;
    logic [15:0] a_dl;
    logic        b_in_ready, b_out_valid, b_out_last, b_drop;
    logic [4:0]  b_ppv;
    logic [15:0] b_dl;

    int errors = 0;
    int checks = 0;

    rc_fork_pipe #(.SPLIT_MC(1)) dut_split (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_mc(in_mc), .in_dst(in_dst), .in_dstList(in_dstList), .portMask(portMask),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ppv(a_ppv),
        .out_dstList(a_dl), .out_last(a_out_last), .drop_pulse(a_drop)
    );

    rc_fork_pipe #(.SPLIT_MC(0)) dut_whole (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_mc(in_mc), .in_dst(in_dst), .in_dstList(in_dstList), .portMask(portMask),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ppv(b_ppv),
        .out_dstList(b_dl), .out_last(b_out_last), .drop_pulse(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] dl;
        logic [4:0]  ppv;
    } uc_vec_t;

    uc_vec_t vecs[8];

    initial begin
        // Node 5 sits at (1,1) in a 4-wide mesh.
        vecs[0] = '{4'd7,  16'h1234, 5'b00010};
        vecs[1] = '{4'd5,  16'h0020, 5'b10000};
        vecs[2] = '{4'd1,  16'hBEEF, 5'b00001};
        vecs[3] = '{4'd13, 16'h0001, 5'b00100};
        vecs[4] = '{4'd4,  16'h8000, 5'b01000};
        vecs[5] = '{4'd0,  16'h5A5A, 5'b01000};
        vecs[6] = '{4'd15, 16'hFFFF, 5'b00010};
        vecs[7] = '{4'd9,  16'h0F0F, 5'b00100};

        reset = 1'b1; in_valid = 1'b0; in_mc = 1'b0; in_dst = '0;
        in_dstList = '0; portMask = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'd0);
        check("rst_out_last",  32'(a_out_last),  32'd0);
        check("rst_drop",      32'(a_drop),      32'd0);
        check("rst_ppv",       32'(a_ppv),       32'd0);
        check("rst_dstlist",   32'(a_dl),        32'd0);
        reset = 1'b0;
        #1 check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

        // Back-to-back unicast stream, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                check("uc_valid", 32'(a_out_valid), 32'd1);
                check("uc_ppv",   32'(a_ppv),       32'(vecs[i-1].ppv));
                check("uc_dl",    32'(a_dl),        32'(vecs[i-1].dl));
                check("uc_last",  32'(a_out_last),  32'd1);
            end
            in_valid = 1'b1; in_mc = 1'b0; in_dst = vecs[i].dst; in_dstList = vecs[i].dl;
            #1 check("uc_in_ready", 32'(a_in_ready), 32'd1);
            next_cycle();
        end
        check("uc_valid", 32'(a_out_valid), 32'd1);
        check("uc_ppv",   32'(a_ppv),       32'(vecs[7].ppv));
        check("uc_dl",    32'(a_dl),        32'(vecs[7].dl));
        in_valid = 1'b0;
        next_cycle();
        check("uc_idle_valid", 32'(a_out_valid), 32'd0);

        // Unicast held by downstream backpressure.
        in_valid = 1'b1; in_dst = 4'd7; in_dstList = 16'h0042;
        next_cycle();
        in_valid = 1'b0; out_ready = 1'b0;
        #1 check("uc_stall_in_ready", 32'(a_in_ready), 32'd0);
        check("uc_stall_ppv", 32'(a_ppv), 32'b00010);
        out_ready = 1'b1;
        #1 check("uc_release_in_ready", 32'(a_in_ready), 32'd1);
        next_cycle();

        // Multicast fork: E and Local reachable.
        portMask[1*16 +: 16] = 16'h00C0;
        portMask[4*16 +: 16] = 16'h0020;
        in_valid = 1'b1; in_mc = 1'b1; in_dst = '0; in_dstList = 16'h00A0;
        next_cycle();
        in_valid = 1'b0;
        check("mc_b1_ppv",      32'(a_ppv),       32'b00010);
        check("mc_b1_dl",       32'(a_dl),        32'h0080);
        check("mc_b1_last",     32'(a_out_last),  32'd0);
        check("mc_b1_in_ready", 32'(a_in_ready),  32'd0);
        check("whole_ppv",      32'(b_ppv),       32'b10010);
        check("whole_dl",       32'(b_dl),        32'h00A0);
        check("whole_last",     32'(b_out_last),  32'd1);
        next_cycle();
        check("mc_b2_ppv",      32'(a_ppv),       32'b10000);
        check("mc_b2_dl",       32'(a_dl),        32'h0020);
        check("mc_b2_last",     32'(a_out_last),  32'd1);
        check("mc_b2_in_ready", 32'(a_in_ready),  32'd1);
        check("whole_done",     32'(b_out_valid), 32'd0);
        next_cycle();
        check("mc_done", 32'(a_out_valid), 32'd0);

        // Stall for three cycles, then reset in the middle of the fork.
        in_valid = 1'b1; out_ready = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 32'(a_out_valid), 32'd1);
            check("stall_ppv",   32'(a_ppv),       32'b00010);
            check("stall_dl",    32'(a_dl),        32'h0080);
            check("stall_last",  32'(a_out_last),  32'd0);
            check("stall_whole", 32'(b_ppv),       32'b10010);
            next_cycle();
        end
        out_ready = 1'b1;
        next_cycle();
        check("resume_ppv", 32'(a_ppv), 32'b10000);
        reset = 1'b1; out_ready = 1'b0;
        next_cycle();
        check("midrst_valid",    32'(a_out_valid), 32'd0);
        check("midrst_in_ready", 32'(a_in_ready),  32'd0);
        reset = 1'b0; out_ready = 1'b1;
        #1 check("after_rst_in_ready", 32'(a_in_ready), 32'd1);
        next_cycle();
        check("after_rst_valid", 32'(a_out_valid), 32'd0);

        // Multicast reaching no port is swallowed.
        portMask = '0;
        in_valid = 1'b1; in_mc = 1'b1; in_dstList = 16'h8000;
        #1 check("drop_in_ready", 32'(a_in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        check("drop_valid", 32'(a_out_valid), 32'd0);
        check("drop_pulse", 32'(a_drop),      32'd1);
        next_cycle();
        check("drop_pulse_end", 32'(a_drop),      32'd0);
        check("drop_no_beat",   32'(a_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
